// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package fetch_pkg;

  typedef enum logic {RUN, HALT} fetch_state_t;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0;
  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage and its surroundings: hazard/branch control
// in, instruction memory port, and the IF/ID register contents out.
interface fetch_if #(
  parameter int N       = 64,
  parameter int IMEM_AW = 6
);

  logic               stall;
  logic               flush;
  logic               pc_src;
  logic [N-1:0]       pc_branch;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_q;
  logic [N-1:0]       if_id_pc;
  logic [31:0]        if_id_instr;
  logic               if_id_valid;
  logic               halted;
  logic [31:0]        fetch_count;

  // Surrounding pipeline and instruction memory
  modport master (
    output stall, flush, pc_src, pc_branch, imem_q,
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
  );

  // The fetch stage itself
  modport slave (
    input  stall, flush, pc_src, pc_branch, imem_q,
    output imem_addr, if_id_pc, if_id_instr, if_id_valid, halted, fetch_count
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: pc, instruction word and valid flag.
// bubble wins over load; with neither asserted every field holds.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         bubble,
  input  logic [N-1:0] pc_in,
  input  logic [31:0]  instr_in,
  output logic [N-1:0] pc_q,
  output logic [31:0]  instr_q,
  output logic         valid_q
);

  logic [N-1:0] pc_d;
  logic [31:0]  instr_d;
  logic         valid_d;

  // Next contents: bubble clears, load captures, otherwise hold
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (bubble) begin
      pc_d    = '0;
      instr_d = BUBBLE_INSTR;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  // Register with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= BUBBLE_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage: PC register, next-PC selection, RUN/HALT
// control and the count of valid instructions handed to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N       = 64,
  parameter int IMEM_AW = 6
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.slave bus
);

  fetch_state_t state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic         load;
  logic         bubble;
  logic [N-1:0] pc_plus;
  logic [N-1:0] branch_target;

  // The low two bits of the redirect target are forced to zero (word aligned)
  assign pc_plus       = pc_q + N'(PC_STEP);
  assign branch_target = bus.pc_branch & ~{{(N-2){1'b0}}, 2'b11};

  // Next state, next PC and IF/ID control; priority pc_src > HALT > flush > stall
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    load          = 1'b0;
    bubble        = 1'b0;
    if (bus.pc_src) begin
      pc_d    = branch_target;
      bubble  = 1'b1;
      state_d = RUN;
    end else if (state_q == HALT) begin
      bubble = 1'b1;
    end else if (bus.flush) begin
      bubble = 1'b1;
      if (!bus.stall) pc_d = pc_plus;
    end else if (bus.stall) begin
      // frozen: nothing changes, zero-word detection suppressed
    end else if (bus.imem_q == BUBBLE_INSTR) begin
      state_d = HALT;
      bubble  = 1'b1;
    end else begin
      load          = 1'b1;
      pc_d          = pc_plus;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State, PC and counter registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .N(N)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .bubble  (bubble),
    .pc_in   (pc_q),
    .instr_in(bus.imem_q),
    .pc_q    (bus.if_id_pc),
    .instr_q (bus.if_id_instr),
    .valid_q (bus.if_id_valid)
  );

  assign bus.imem_addr   = pc_q[IMEM_AW+1:2];
  assign bus.halted      = (state_q == HALT);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner
// sequences (PC wrap, asynchronous reset) and a randomized run against a
// rule-level reference model.
module tb_fetch_stage;

  localparam int N       = 64;
  localparam int IMEM_AW = 6;

  logic clk;
  logic reset;
  logic [31:0] mem [64];

  fetch_if #(.N(N), .IMEM_AW(IMEM_AW)) bus ();

  fetch_stage #(.N(N), .IMEM_AW(IMEM_AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.imem_q = mem[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        st, fl, ps;
    logic [63:0] br;
    logic [5:0]  addr;
    logic [63:0] ifpc;
    logic [31:0] instr;
    logic        valid, halt;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  // reference model state
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid, m_halt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic row(input logic st, fl, ps, input logic [63:0] br, input logic [5:0] addr,
                     input logic [63:0] ifpc, input logic [31:0] instr,
                     input logic valid, halt, input logic [31:0] cnt);
    vec_t v;
    v.st = st; v.fl = fl; v.ps = ps; v.br = br; v.addr = addr; v.ifpc = ifpc;
    v.instr = instr; v.valid = valid; v.halt = halt; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic st, fl, ps, input logic [63:0] br);
    bus.stall = st; bus.flush = fl; bus.pc_src = ps; bus.pc_branch = br;
  endtask

  task automatic check_all(input string tag, input logic [5:0] addr, input logic [63:0] ifpc,
                           input logic [31:0] instr, input logic valid, halt,
                           input logic [31:0] cnt);
    check({tag, ".imem_addr"},   64'(bus.imem_addr),   64'(addr));
    check({tag, ".if_id_pc"},    bus.if_id_pc,         ifpc);
    check({tag, ".if_id_instr"}, 64'(bus.if_id_instr), 64'(instr));
    check({tag, ".if_id_valid"}, 64'(bus.if_id_valid), 64'(valid));
    check({tag, ".halted"},      64'(bus.halted),      64'(halt));
    check({tag, ".fetch_count"}, 64'(bus.fetch_count), 64'(cnt));
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 64'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_pc = 0; m_ifpc = 0; m_instr = 0; m_cnt = 0; m_valid = 0; m_halt = 0;
  endtask

  // Apply the fetch rules for one clock edge to the model
  task automatic model_edge(input logic st, fl, ps, input logic [63:0] br);
    logic [31:0] word;
    logic        bub;
    word = mem[m_pc[7:2]];
    bub  = 1'b0;
    if (ps) begin
      m_pc   = {br[63:2], 2'b00};
      m_halt = 1'b0;
      bub    = 1'b1;
    end else if (m_halt) begin
      bub = 1'b1;
    end else if (fl) begin
      bub = 1'b1;
      if (!st) m_pc = m_pc + 64'd4;
    end else if (st) begin
      bub = 1'b0;
    end else if (word == 32'h0) begin
      m_halt = 1'b1;
      bub    = 1'b1;
    end else begin
      m_ifpc  = m_pc;
      m_instr = word;
      m_valid = 1'b1;
      m_pc    = m_pc + 64'd4;
      m_cnt   = m_cnt + 32'd1;
    end
    if (bub) begin
      m_ifpc = 0; m_instr = 0; m_valid = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 64'h0);
    for (int i = 0; i < 64; i++) mem[i] = 32'h8b00_0000 | 32'(i);
    mem[0]  = 32'h9100_2809;
    mem[1]  = 32'hcb09_014a;
    mem[2]  = 32'hb400_00aa;
    mem[19] = 32'h0;

    // reset state
    #12;
    check_all("reset", 6'd0, 64'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    //   st fl ps  br            addr   ifpc   instr          v  h  cnt
    row(0, 0, 0, 64'h0,  6'd1,  64'h0,  32'h9100_2809, 1, 0, 32'd1);
    row(0, 0, 0, 64'h0,  6'd2,  64'h4,  32'hcb09_014a, 1, 0, 32'd2);
    row(1, 0, 0, 64'h0,  6'd2,  64'h4,  32'hcb09_014a, 1, 0, 32'd2);
    row(1, 0, 0, 64'h0,  6'd2,  64'h4,  32'hcb09_014a, 1, 0, 32'd2);
    row(0, 0, 0, 64'h0,  6'd3,  64'h8,  32'hb400_00aa, 1, 0, 32'd3);
    row(1, 0, 1, 64'h30, 6'd12, 64'h0,  32'h0,         0, 0, 32'd3);
    row(0, 0, 0, 64'h0,  6'd13, 64'h30, 32'h8b00_000c, 1, 0, 32'd4);
    row(0, 0, 1, 64'h13, 6'd4,  64'h0,  32'h0,         0, 0, 32'd4);
    row(0, 1, 0, 64'h0,  6'd5,  64'h0,  32'h0,         0, 0, 32'd4);
    row(1, 1, 0, 64'h0,  6'd5,  64'h0,  32'h0,         0, 0, 32'd4);
    row(0, 0, 1, 64'h48, 6'd18, 64'h0,  32'h0,         0, 0, 32'd4);
    row(0, 0, 0, 64'h0,  6'd19, 64'h48, 32'h8b00_0012, 1, 0, 32'd5);
    row(0, 0, 0, 64'h0,  6'd19, 64'h0,  32'h0,         0, 1, 32'd5);
    row(1, 1, 0, 64'h0,  6'd19, 64'h0,  32'h0,         0, 1, 32'd5);
    row(0, 0, 1, 64'h0,  6'd0,  64'h0,  32'h0,         0, 0, 32'd5);
    row(0, 0, 0, 64'h0,  6'd1,  64'h0,  32'h9100_2809, 1, 0, 32'd6);
    row(0, 0, 0, 64'h0,  6'd2,  64'h4,  32'hcb09_014a, 1, 0, 32'd7);
    row(0, 1, 0, 64'h0,  6'd3,  64'h0,  32'h0,         0, 0, 32'd7);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].ps, tbl[i].br);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].addr, tbl[i].ifpc, tbl[i].instr,
                tbl[i].valid, tbl[i].halt, tbl[i].cnt);
    end

    // PC wrap: redirect to the last word of the address space, then fetch
    drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk);
    #1;
    check_all("wrap_redirect", 6'd63, 64'h0, 32'h0, 1'b0, 1'b0, 32'd7);
    drive(0, 0, 0, 64'h0);
    @(posedge clk);
    #1;
    check_all("wrap_fetch", 6'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h8b00_003f, 1'b1, 1'b0, 32'd8);

    // Asynchronous reset between edges
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_all("async_reset", 6'd0, 64'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Randomized run against the model
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic        st, fl, ps;
      logic [63:0] br;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      ps = ($urandom_range(0, 15) == 0) || (m_halt && $urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                       : 64'($urandom_range(0, 255));
      drive(st, fl, ps, br);
      @(posedge clk);
      model_edge(st, fl, ps, br);
      #1;
      check_all($sformatf("rnd%0d", c), m_pc[7:2], m_ifpc, m_instr, m_valid, m_halt, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
